noc_req_depacketizer: RTL and testbench

Upstream request stage of the NoC-to-AXI master path in the memory tile. Pops flits from the coherence request queue, parses and checks the header, address and length flits, and presents one decoded request descriptor to the AXI master engine. For write packets it then forwards the payload flits as a beat stream with `last` marking. Malformed or misrouted packets are drained up to their tail and flagged, so the downstream AXI engine only ever sees well-formed requests.

---
 rtl/noc_axi_pkg.sv | 32 +++
 rtl/noc_hdr_fields.sv | 41 ++++
 rtl/noc_req_depacketizer.sv | 187 ++++++++++++++++++
 tb/tb_noc_req_depacketizer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_axi_pkg.sv
// Shared definitions for the NoC <-> AXI master path: flit layout, message codes
// and the request depacketizer state encoding.
package noc_axi_pkg;

    localparam int NOC_FLIT_W = 34;
    localparam int ARCH_W     = 32;

    localparam logic [1:0] PRE_BODY = 2'b00;
    localparam logic [1:0] PRE_TAIL = 2'b01;
    localparam logic [1:0] PRE_HDR  = 2'b10;
    localparam logic [1:0] PRE_ONE  = 2'b11;

    localparam int HDR_OY_LSB  = 29;
    localparam int HDR_OX_LSB  = 26;
    localparam int HDR_DY_LSB  = 23;
    localparam int HDR_DX_LSB  = 20;
    localparam int HDR_MSG_LSB = 15;
    localparam int HDR_RSV_LSB = 7;

    localparam logic [4:0] MSG_AXI_RD = 5'd1;
    localparam logic [4:0] MSG_AXI_WR = 5'd2;

    typedef enum logic [2:0] {
        HDR,
        ADDR,
        LEN,
        DESC,
        DATA,
        DRAIN
    } depkt_state_t;

endpackage

// File: rtl/noc_hdr_fields.sv
// Combinational header decode: splits a flit into preamble, origin, message and
// prot bits, and flags whether it is an acceptable request header for this tile.
module noc_hdr_fields
    import noc_axi_pkg::*;
#(
    parameter int NOC_FLIT_SIZE = 34,
    parameter int ARCH_BITS     = 32,
    parameter bit CHECK_DEST    = 1'b1
) (
    input  logic [NOC_FLIT_SIZE-1:0] i_flit,
    input  logic [2:0]               i_local_y,
    input  logic [2:0]               i_local_x,
    output logic [1:0]               o_preamble,
    output logic [2:0]               o_orig_y,
    output logic [2:0]               o_orig_x,
    output logic [4:0]               o_msg,
    output logic [2:0]               o_prot,
    output logic [ARCH_BITS-1:0]     o_payload,
    output logic                     o_hdr_ok
);

    logic [2:0] w_dest_y;
    logic [2:0] w_dest_x;
    logic       w_msg_ok;
    logic       w_dest_ok;

    assign o_preamble = i_flit[NOC_FLIT_SIZE-1 -: 2];
    assign o_payload  = i_flit[ARCH_BITS-1:0];
    assign o_orig_y   = i_flit[HDR_OY_LSB +: 3];
    assign o_orig_x   = i_flit[HDR_OX_LSB +: 3];
    assign w_dest_y   = i_flit[HDR_DY_LSB +: 3];
    assign w_dest_x   = i_flit[HDR_DX_LSB +: 3];
    assign o_msg      = i_flit[HDR_MSG_LSB +: 5];
    // Only the low three reserved bits carry meaning (AXI prot).
    assign o_prot     = i_flit[HDR_RSV_LSB +: 3];

    assign w_msg_ok  = (o_msg == MSG_AXI_RD) || (o_msg == MSG_AXI_WR);
    assign w_dest_ok = !CHECK_DEST || ((w_dest_y == i_local_y) && (w_dest_x == i_local_x));
    assign o_hdr_ok  = (o_preamble == PRE_HDR) && w_msg_ok && w_dest_ok;

endmodule

// File: rtl/noc_req_depacketizer.sv
// Parses NoC request packets into one AXI request descriptor plus, for writes,
// a write-beat stream; malformed packets are drained to their tail and flagged.
module noc_req_depacketizer
    import noc_axi_pkg::*;
#(
    parameter int NOC_FLIT_SIZE = 34,
    parameter int ARCH_BITS     = 32,
    parameter bit CHECK_DEST    = 1'b1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [2:0]               local_y,
    input  logic [2:0]               local_x,
    input  logic [NOC_FLIT_SIZE-1:0] coherence_req_data_out,
    input  logic                     coherence_req_empty,
    output logic                     coherence_req_rdreq,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic                     req_write,
    output logic [ARCH_BITS-1:0]     req_addr,
    output logic [7:0]               req_len,
    output logic [2:0]               req_prot,
    output logic [2:0]               req_src_y,
    output logic [2:0]               req_src_x,
    output logic                     wd_valid,
    input  logic                     wd_ready,
    output logic [ARCH_BITS-1:0]     wd_data,
    output logic                     wd_last,
    output logic                     pkt_err
);

    logic [1:0]           w_pre;
    logic [2:0]           w_orig_y;
    logic [2:0]           w_orig_x;
    logic [4:0]           w_msg;
    logic [2:0]           w_prot;
    logic [ARCH_BITS-1:0] w_payload;
    logic                 w_hdr_ok;
    logic                 w_tail;

    depkt_state_t         r_state;
    depkt_state_t         w_next;
    logic                 r_req_valid;
    logic                 r_req_write;
    logic [ARCH_BITS-1:0] r_req_addr;
    logic [7:0]           r_req_len;
    logic [2:0]           r_req_prot;
    logic [2:0]           r_src_y;
    logic [2:0]           r_src_x;
    logic [7:0]           r_count;

    logic w_pop, w_err, w_wd_valid, w_wd_last;
    logic w_ld_hdr, w_ld_addr, w_ld_len, w_accept, w_dec;

    noc_hdr_fields #(
        .NOC_FLIT_SIZE (NOC_FLIT_SIZE),
        .ARCH_BITS     (ARCH_BITS),
        .CHECK_DEST    (CHECK_DEST)
    ) u_hdr_fields (
        .i_flit     (coherence_req_data_out),
        .i_local_y  (local_y),
        .i_local_x  (local_x),
        .o_preamble (w_pre),
        .o_orig_y   (w_orig_y),
        .o_orig_x   (w_orig_x),
        .o_msg      (w_msg),
        .o_prot     (w_prot),
        .o_payload  (w_payload),
        .o_hdr_ok   (w_hdr_ok)
    );

    assign w_tail = (w_pre == PRE_TAIL);

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_err      = 1'b0;
        w_wd_valid = 1'b0;
        w_wd_last  = 1'b0;
        w_ld_hdr   = 1'b0;
        w_ld_addr  = 1'b0;
        w_ld_len   = 1'b0;
        w_accept   = 1'b0;
        w_dec      = 1'b0;
        case (r_state)
            HDR: if (!coherence_req_empty) begin
                w_pop = 1'b1;
                if (w_hdr_ok) begin
                    w_ld_hdr = 1'b1;
                    w_next   = ADDR;
                end else begin
                    // A one-flit packet is already complete; nothing to drain.
                    w_err  = 1'b1;
                    w_next = (w_pre == PRE_ONE) ? HDR : DRAIN;
                end
            end
            ADDR: if (!coherence_req_empty) begin
                w_pop = 1'b1;
                if (w_pre == PRE_BODY) begin
                    w_ld_addr = 1'b1;
                    w_next    = LEN;
                end else begin
                    w_err  = 1'b1;
                    w_next = w_tail ? HDR : DRAIN;
                end
            end
            LEN: if (!coherence_req_empty) begin
                w_pop = 1'b1;
                if (w_pre == (r_req_write ? PRE_BODY : PRE_TAIL)) begin
                    w_ld_len = 1'b1;
                    w_next   = DESC;
                end else begin
                    w_err  = 1'b1;
                    w_next = w_tail ? HDR : DRAIN;
                end
            end
            DESC: if (r_req_valid && req_ready) begin
                w_accept = 1'b1;
                w_next   = r_req_write ? DATA : HDR;
            end
            DATA: begin
                w_wd_valid = !coherence_req_empty;
                w_wd_last  = (r_count == 8'd0) || w_tail;
                if (w_wd_valid && wd_ready) begin
                    w_pop = 1'b1;
                    w_dec = (r_count != 8'd0);
                    if (w_tail) begin
                        w_err  = (r_count != 8'd0);
                        w_next = HDR;
                    end else if ((r_count == 8'd0) || w_pre[1]) begin
                        w_err  = 1'b1;
                        w_next = DRAIN;
                    end
                end
            end
            DRAIN: if (!coherence_req_empty) begin
                w_pop = 1'b1;
                if (w_tail) w_next = HDR;
            end
            default: w_next = HDR;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= HDR;
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_len   <= '0;
            r_req_prot  <= '0;
            r_src_y     <= '0;
            r_src_x     <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_hdr) begin
                r_req_write <= (w_msg == MSG_AXI_WR);
                r_req_prot  <= w_prot;
                r_src_y     <= w_orig_y;
                r_src_x     <= w_orig_x;
            end
            if (w_ld_addr) r_req_addr <= w_payload;
            if (w_ld_len) begin
                r_req_len   <= w_payload[7:0];
                r_count     <= w_payload[7:0];
                r_req_valid <= 1'b1;
            end
            if (w_accept) r_req_valid <= 1'b0;
            if (w_dec)    r_count     <= r_count - 8'd1;
        end
    end

    assign coherence_req_rdreq = w_pop && !ARESET;
    assign pkt_err             = w_err && !ARESET;
    assign wd_valid            = w_wd_valid && !ARESET;
    assign wd_last             = w_wd_last && !ARESET;
    assign wd_data             = w_payload;
    assign req_valid           = r_req_valid;
    assign req_write           = r_req_write;
    assign req_addr            = r_req_addr;
    assign req_len             = r_req_len;
    assign req_prot            = r_req_prot;
    assign req_src_y           = r_src_y;
    assign req_src_x           = r_src_x;

endmodule

// File: tb/tb_noc_req_depacketizer.sv
// Directed bench for noc_req_depacketizer: a model FWFT queue feeds hand-built
// packets and every observation is checked against hand-computed values.
module tb_noc_req_depacketizer;
    import noc_axi_pkg::*;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b1;
    logic [2:0]  local_y = 3'd0;
    logic [2:0]  local_x = 3'd0;
    logic [33:0] coherence_req_data_out;
    logic        coherence_req_empty;
    logic        coherence_req_rdreq;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_prot;
    logic [2:0]  req_src_y;
    logic [2:0]  req_src_x;
    logic        wd_valid;
    logic        wd_ready = 1'b0;
    logic [31:0] wd_data;
    logic        wd_last;
    logic        pkt_err;

    always #5 ACLK = ~ACLK;

    noc_req_depacketizer #(
        .NOC_FLIT_SIZE (34),
        .ARCH_BITS     (32),
        .CHECK_DEST    (1'b1)
    ) dut (
        .ACLK                   (ACLK),
        .ARESET                 (ARESET),
        .local_y                (local_y),
        .local_x                (local_x),
        .coherence_req_data_out (coherence_req_data_out),
        .coherence_req_empty    (coherence_req_empty),
        .coherence_req_rdreq    (coherence_req_rdreq),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_write              (req_write),
        .req_addr               (req_addr),
        .req_len                (req_len),
        .req_prot               (req_prot),
        .req_src_y              (req_src_y),
        .req_src_x              (req_src_x),
        .wd_valid               (wd_valid),
        .wd_ready               (wd_ready),
        .wd_data                (wd_data),
        .wd_last                (wd_last),
        .pkt_err                (pkt_err)
    );

    // Model first-word-fall-through queue
    logic [33:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    assign coherence_req_empty    = (rd_ptr == wr_ptr);
    assign coherence_req_data_out = mem[rd_ptr];

    // Event monitors
    int          cyc = 0, np = 0, ne = 0, nvld = 0, nhs = 0, nb = 0;
    int          hs_cyc  [0:255];
    logic [31:0] hs_addr [0:255];
    logic [31:0] bd [0:255];
    logic        bl [0:255];

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (coherence_req_rdreq && !coherence_req_empty) begin
            rd_ptr <= rd_ptr + 8'd1;
            np     <= np + 1;
        end
        if (pkt_err)   ne   <= ne + 1;
        if (req_valid) nvld <= nvld + 1;
        if (req_valid && req_ready) begin
            hs_cyc[nhs[7:0]]  <= cyc;
            hs_addr[nhs[7:0]] <= req_addr;
            nhs <= nhs + 1;
        end
        if (wd_valid && wd_ready) begin
            bd[nb[7:0]] <= wd_data;
            bl[nb[7:0]] <= wd_last;
            nb <= nb + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge ACLK);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!req_valid && k < 30) begin
            tick();
            k++;
        end
        n_cmp++;
        assert (req_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: req_valid observed %0b required 1 within 30 cycles", tag, req_valid);
        end
    endtask

    task automatic push(input logic [33:0] f);
        mem[wr_ptr] = f;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    function automatic logic [33:0] hdr(input logic [2:0] oy, input logic [2:0] ox,
                                        input logic [2:0] dy, input logic [2:0] dx,
                                        input logic [4:0] msg, input logic [7:0] rsv);
        return {2'b10, oy, ox, dy, dx, msg, rsv, 7'd0};
    endfunction

    function automatic logic [33:0] fl(input logic [1:0] pre, input logic [31:0] d);
        return {pre, d};
    endfunction

    int np0, ne0, nb0, nvld0, nhs0;

    initial begin
        tick(); tick();
        chk("rst_req_valid", 64'(req_valid), 64'h0);
        chk("rst_wd_valid",  64'(wd_valid),  64'h0);
        chk("rst_pkt_err",   64'(pkt_err),   64'h0);
        chk("rst_req_addr",  64'(req_addr),  64'h0);
        chk("rst_req_len",   64'(req_len),   64'h0);

        // Read: descriptor in cycle 3, held while req_ready low
        push(hdr(3'd1, 3'd2, 3'd0, 3'd0, 5'd1, 8'h05));
        push(fl(2'b00, 32'h8000_0040));
        push(fl(2'b01, 32'h0000_0007));
        #1;
        chk("rst_rdreq", 64'(coherence_req_rdreq), 64'h0);
        ARESET = 1'b0;
        tick(); tick();
        chk("rd_not_early", 64'(req_valid), 64'h0);
        tick();
        chk("rd_valid",  64'(req_valid), 64'h1);
        chk("rd_write",  64'(req_write), 64'h0);
        chk("rd_addr",   64'(req_addr),  64'h8000_0040);
        chk("rd_len",    64'(req_len),   64'h7);
        chk("rd_prot",   64'(req_prot),  64'h5);
        chk("rd_src_y",  64'(req_src_y), 64'h1);
        chk("rd_src_x",  64'(req_src_x), 64'h2);

        push(hdr(3'd1, 3'd2, 3'd0, 3'd0, 5'd2, 8'h00));
        push(fl(2'b00, 32'h0000_1000));
        push(fl(2'b00, 32'h0000_0003));
        for (int i = 0; i < 4; i++) push(fl((i == 3) ? 2'b01 : 2'b00, 32'hA0 + 32'(i)));
        np0 = np;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 64'(req_valid), 64'h1);
            chk("hold_addr",  64'(req_addr),  64'h8000_0040);
            chk("hold_len",   64'(req_len),   64'h7);
            chk("hold_rdreq", 64'(coherence_req_rdreq), 64'h0);
        end
        chk("hold_no_pop", 64'(np - np0), 64'h0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("rd_accept", 64'(req_valid), 64'h0);

        // Write len 3 with wd_ready toggling
        wait_valid("wr_desc");
        chk("wr_write", 64'(req_write), 64'h1);
        chk("wr_addr",  64'(req_addr),  64'h1000);
        chk("wr_len",   64'(req_len),   64'h3);
        nb0 = nb;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wd_ready = (i % 2 == 0);
            #1;
            if (i == 1) chk("wr_stall_rdreq", 64'(coherence_req_rdreq), 64'h0);
            if (i == 4) chk("wr_mid_last", 64'(wd_last), 64'h0);
            if (i == 6) begin
                chk("wr_last_live", 64'(wd_last), 64'h1);
                chk("wr_last_data", 64'(wd_data), 64'hA3);
            end
            tick();
        end
        wd_ready = 1'b0;
        chk("wr_beats", 64'(nb - nb0), 64'h4);
        for (int k = 0; k < 4; k++) begin
            chk("wr_data", 64'(bd[8'(nb0 + k)]), 64'(32'hA0 + 32'(k)));
            chk("wr_last", 64'(bl[8'(nb0 + k)]), 64'((k == 3) ? 1 : 0));
        end
        chk("wr_state", 64'(dut.r_state), 64'(HDR));
        chk("wr_no_err", 64'(ne), 64'h0);

        // Early tail, then a clean read
        ne0 = ne; nb0 = nb;
        push(hdr(3'd1, 3'd2, 3'd0, 3'd0, 5'd2, 8'h00));
        push(fl(2'b00, 32'h2000_0000));
        push(fl(2'b00, 32'h0000_0003));
        push(fl(2'b00, 32'h0000_00B0));
        push(fl(2'b01, 32'h0000_00B1));
        push(hdr(3'd3, 3'd4, 3'd0, 3'd0, 5'd1, 8'h02));
        push(fl(2'b00, 32'h0000_2000));
        push(fl(2'b01, 32'h0000_0001));
        wait_valid("et_desc");
        chk("et_len", 64'(req_len), 64'h3);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        wd_ready  = 1'b1;
        tick(); tick(); tick();
        wd_ready  = 1'b0;
        wait_valid("et_next");
        chk("et_next_write", 64'(req_write), 64'h0);
        chk("et_next_addr",  64'(req_addr),  64'h2000);
        chk("et_next_len",   64'(req_len),   64'h1);
        chk("et_next_prot",  64'(req_prot),  64'h2);
        chk("et_next_src_y", 64'(req_src_y), 64'h3);
        chk("et_next_src_x", 64'(req_src_x), 64'h4);
        chk("et_beats", 64'(nb - nb0), 64'h2);
        chk("et_data0", 64'(bd[8'(nb0)]), 64'hB0);
        chk("et_last0", 64'(bl[8'(nb0)]), 64'h0);
        chk("et_data1", 64'(bd[8'(nb0 + 1)]), 64'hB1);
        chk("et_last1", 64'(bl[8'(nb0 + 1)]), 64'h1);
        chk("et_err", 64'(ne - ne0), 64'h1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;

        // Bad message type, then wrong destination
        for (int t = 0; t < 2; t++) begin
            np0 = np; ne0 = ne; nvld0 = nvld;
            if (t == 0) push(hdr(3'd1, 3'd1, 3'd0, 3'd0, 5'd9, 8'h00));
            else        push(hdr(3'd1, 3'd1, 3'd3, 3'd3, 5'd1, 8'h00));
            push(fl(2'b00, 32'h1));
            push(fl(2'b00, 32'h2));
            push(fl(2'b01, 32'h3));
            repeat (8) tick();
            chk("bh_pops",  64'(np - np0),     64'h4);
            chk("bh_err",   64'(ne - ne0),     64'h1);
            chk("bh_valid", 64'(nvld - nvld0), 64'h0);
        end

        // Reset during beat 2 of 8, leftovers drained, then a clean read
        nb0 = nb; ne0 = ne;
        push(hdr(3'd1, 3'd2, 3'd0, 3'd0, 5'd2, 8'h01));
        push(fl(2'b00, 32'h4000_0100));
        push(fl(2'b00, 32'h0000_0007));
        for (int i = 0; i < 8; i++) push(fl((i == 7) ? 2'b01 : 2'b00, 32'hC0 + 32'(i)));
        wait_valid("rs_desc");
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        wd_ready  = 1'b1;
        tick();
        ARESET = 1'b1;
        #1;
        chk("rs_wd_valid", 64'(wd_valid), 64'h0);
        chk("rs_rdreq",    64'(coherence_req_rdreq), 64'h0);
        tick();
        chk("rs_state",    64'(dut.r_state), 64'(HDR));
        chk("rs_count",    64'(dut.r_count), 64'h0);
        chk("rs_valid",    64'(req_valid),   64'h0);
        chk("rs_addr",     64'(req_addr),    64'h0);
        chk("rs_write",    64'(req_write),   64'h0);
        chk("rs_wd_last",  64'(wd_last),     64'h0);
        chk("rs_pkt_err",  64'(pkt_err),     64'h0);
        chk("rs_beats",    64'(nb - nb0),    64'h1);
        ARESET   = 1'b0;
        wd_ready = 1'b0;
        push(hdr(3'd2, 3'd5, 3'd0, 3'd0, 5'd1, 8'h07));
        push(fl(2'b00, 32'h3000_0000));
        push(fl(2'b01, 32'h0000_000F));
        wait_valid("rs_next");
        chk("rs_next_addr",  64'(req_addr),  64'h3000_0000);
        chk("rs_next_len",   64'(req_len),   64'hF);
        chk("rs_next_prot",  64'(req_prot),  64'h7);
        chk("rs_next_src_y", 64'(req_src_y), 64'h2);
        chk("rs_next_src_x", 64'(req_src_x), 64'h5);
        chk("rs_err",        64'(ne - ne0),  64'h1);
        chk("rs_beats_after",64'(nb - nb0),  64'h1);
        req_ready = 1'b1;
        tick();

        // Back-to-back reads with req_ready held high
        np0 = np; nhs0 = nhs;
        for (int i = 1; i <= 3; i++) begin
            push(hdr(3'd0, 3'd1, 3'd0, 3'd0, 5'd1, 8'h00));
            push(fl(2'b00, 32'(i) * 32'h100));
            push(fl(2'b01, 32'h0));
        end
        repeat (16) tick();
        req_ready = 1'b0;
        chk("b2b_count", 64'(nhs - nhs0), 64'h3);
        chk("b2b_gap1",  64'(hs_cyc[8'(nhs0 + 1)] - hs_cyc[8'(nhs0)]), 64'h4);
        chk("b2b_gap2",  64'(hs_cyc[8'(nhs0 + 2)] - hs_cyc[8'(nhs0 + 1)]), 64'h4);
        chk("b2b_addr0", 64'(hs_addr[8'(nhs0)]),     64'h100);
        chk("b2b_addr1", 64'(hs_addr[8'(nhs0 + 1)]), 64'h200);
        chk("b2b_addr2", 64'(hs_addr[8'(nhs0 + 2)]), 64'h300);
        chk("b2b_pops",  64'(np - np0), 64'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
